ddr_arbiter: RTL and testbench

DDR_ARBITER -- requirements
Module: ddr_arbiter

---
 rtl/ddr_arbiter.sv | 131 +++++++++++++
 tb/tb_ddr_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_arbiter.sv
// DDR command arbiter: VGA reads, drawing-engine writes and periodic auto-refresh
// share one command channel to the DDR sequencer.
module ddr_arbiter #(
  parameter int REFRESH_INTERVAL = 1000,
  parameter int MAX_RD_STREAK    = 8
) (
  input  logic        clk133,
  input  logic        rst,
  input  logic        initDone,
  input  logic        rdReq,
  input  logic [23:0] rdAddr,
  output logic        rdGnt,
  input  logic        wrReq,
  input  logic [23:0] wrAddr,
  input  logic [31:0] wrData,
  output logic        wrGnt,
  output logic        cmdValid,
  output logic [1:0]  cmdOp,
  output logic [23:0] cmdAddr,
  output logic [31:0] cmdData,
  input  logic        cmdReady,
  input  logic        cmdDone,
  output logic        refreshOverflow,
  output logic [1:0]  dbg_state
);
  // Handshake: a command transfers on a rising edge where cmdValid=1 and cmdReady=1;
  // until then cmdValid and its payload are frozen. cmdDone (one cycle) closes it.
  localparam int CW = $clog2(REFRESH_INTERVAL + 1);
  localparam int SW = $clog2(MAX_RD_STREAK + 1);
  localparam logic [CW-1:0] REF_RELOAD = CW'(REFRESH_INTERVAL - 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_RD_STREAK);

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_WR   = 2'b10;
  localparam logic [1:0] OP_REF  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   ref_cnt;
  logic [3:0]      ref_pending;
  logic [SW-1:0]   rd_streak;
  logic [1:0]      win_op;
  logic            tick;
  logic            ref_accept;

  assign dbg_state  = state_q;
  assign tick       = initDone && (ref_cnt == '0);
  assign ref_accept = (state_q == S_ISSUE) && cmdReady && (cmdOp == OP_REF);

  // Fixed-priority pick; urgent refresh and starved writes jump ahead of reads.
  always_comb begin
    win_op = OP_NONE;
    if (initDone && state_q == S_IDLE) begin
      if (ref_pending >= 4'd4)                  win_op = OP_REF;
      else if (wrReq && rd_streak >= STREAK_MAX) win_op = OP_WR;
      else if (rdReq)                           win_op = OP_RD;
      else if (ref_pending != 4'd0)             win_op = OP_REF;
      else if (wrReq)                           win_op = OP_WR;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (win_op != OP_NONE) state_d = S_ISSUE;
      S_ISSUE: if (cmdReady)          state_d = S_WAIT;
      S_WAIT:  if (cmdDone)           state_d = S_IDLE;
      default:                        state_d = S_IDLE;
    endcase
    if (!initDone) state_d = S_IDLE;
  end

  always_ff @(posedge clk133) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk133) begin
    if (rst || !initDone) begin
      ref_cnt     <= REF_RELOAD;
      ref_pending <= 4'd0;
      rd_streak   <= '0;
      rdGnt       <= 1'b0;
      wrGnt       <= 1'b0;
      cmdValid    <= 1'b0;
      cmdOp       <= OP_NONE;
      cmdAddr     <= '0;
      cmdData     <= '0;
    end else begin
      ref_cnt <= (ref_cnt == '0) ? REF_RELOAD : ref_cnt - 1'b1;

      // A tick arriving with a full backlog and no drain is lost.
      if (tick && !ref_accept) begin
        if (ref_pending != 4'd8) ref_pending <= ref_pending + 4'd1;
      end else if (!tick && ref_accept) begin
        ref_pending <= ref_pending - 4'd1;
      end

      if (!wrReq || win_op == OP_WR)
        rd_streak <= '0;
      else if (win_op == OP_RD && rd_streak != STREAK_MAX)
        rd_streak <= rd_streak + 1'b1;

      rdGnt <= (win_op == OP_RD);
      wrGnt <= (win_op == OP_WR);

      if (win_op != OP_NONE) begin
        cmdValid <= 1'b1;
        cmdOp    <= win_op;
        cmdAddr  <= (win_op == OP_RD) ? rdAddr : (win_op == OP_WR) ? wrAddr : 24'h0;
        cmdData  <= (win_op == OP_WR) ? wrData : 32'h0;
      end else if (state_q == S_ISSUE && cmdReady) begin
        cmdValid <= 1'b0;
        cmdOp    <= OP_NONE;
        cmdAddr  <= '0;
        cmdData  <= '0;
      end
    end
  end

  // Sticky across initDone drops; only rst clears it.
  always_ff @(posedge clk133) begin
    if (rst)
      refreshOverflow <= 1'b0;
    else if (initDone && tick && !ref_accept && ref_pending == 4'd8)
      refreshOverflow <= 1'b1;
  end

endmodule

// File: tb/tb_ddr_arbiter.sv
// Bench for ddr_arbiter: transaction-level reference model feeding an expected
// command queue, an independent output monitor, and directed corner scenarios.
module tb_ddr_arbiter;
  localparam int RI   = 50;
  localparam int MAXS = 8;
  localparam logic [1:0] OP_RD  = 2'b01;
  localparam logic [1:0] OP_WR  = 2'b10;
  localparam logic [1:0] OP_REF = 2'b11;
  localparam int P_FREE = 0;
  localparam int P_ISS  = 1;
  localparam int P_WAIT = 2;

  logic        clk133 = 1'b0;
  logic        rst = 1'b1, initDone = 1'b0;
  logic        rdReq = 1'b0, wrReq = 1'b0, cmdReady = 1'b0, cmdDone = 1'b0;
  logic [23:0] rdAddr = '0, wrAddr = '0;
  logic [31:0] wrData = '0;
  logic        rdGnt, wrGnt, cmdValid, refreshOverflow;
  logic [1:0]  cmdOp, dbg_state;
  logic [23:0] cmdAddr;
  logic [31:0] cmdData;

  int n_checks = 0;
  int n_fail   = 0;
  logic [57:0] exp_q[$];

  // reference model state: bus occupancy, refresh backlog, read streak
  int       m_run = 0, m_pend = 0, m_streak = 0, m_phase = P_FREE, m_done_wait = 0;
  bit       m_ovf = 0, m_rd_win = 0, m_wr_win = 0;
  logic [1:0] m_op = 2'b00;

  always #5 clk133 = ~clk133;

  ddr_arbiter #(.REFRESH_INTERVAL(RI), .MAX_RD_STREAK(MAXS)) dut (
    .clk133(clk133), .rst(rst), .initDone(initDone),
    .rdReq(rdReq), .rdAddr(rdAddr), .rdGnt(rdGnt),
    .wrReq(wrReq), .wrAddr(wrAddr), .wrData(wrData), .wrGnt(wrGnt),
    .cmdValid(cmdValid), .cmdOp(cmdOp), .cmdAddr(cmdAddr), .cmdData(cmdData),
    .cmdReady(cmdReady), .cmdDone(cmdDone), .refreshOverflow(refreshOverflow),
    .dbg_state(dbg_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decides, from the inputs about to be sampled, what the arbiter should do at the next edge.
  task automatic model_step();
    bit tick, ref_acc;
    logic [1:0] op;
    m_rd_win = 0;
    m_wr_win = 0;
    op = 2'b00;
    if (rst) begin
      m_run = 0; m_pend = 0; m_streak = 0; m_phase = P_FREE; m_ovf = 0;
    end else if (!initDone) begin
      m_run = 0; m_pend = 0; m_streak = 0; m_phase = P_FREE;
    end else begin
      tick = (m_run % RI) == RI - 1;
      m_run++;
      ref_acc = (m_phase == P_ISS) && cmdReady && (m_op == OP_REF);
      case (m_phase)
        P_FREE: begin
          if (m_pend >= 4)                   op = OP_REF;
          else if (wrReq && m_streak >= MAXS) op = OP_WR;
          else if (rdReq)                    op = OP_RD;
          else if (m_pend > 0)               op = OP_REF;
          else if (wrReq)                    op = OP_WR;
        end
        P_ISS: if (cmdReady) begin
          m_phase = P_WAIT;
          m_done_wait = $urandom_range(0, 3);
        end
        default: if (cmdDone) m_phase = P_FREE;
      endcase
      if (op != 2'b00) begin
        m_phase = P_ISS;
        m_op = op;
        m_rd_win = (op == OP_RD);
        m_wr_win = (op == OP_WR);
        exp_q.push_back({op, (op == OP_RD) ? rdAddr : (op == OP_WR) ? wrAddr : 24'h0,
                         (op == OP_WR) ? wrData : 32'h0});
      end
      m_pend = m_pend + int'(tick) - int'(ref_acc);
      if (m_pend > 8) begin
        m_pend = 8;
        m_ovf = 1;
      end
      if (!wrReq || op == OP_WR) m_streak = 0;
      else if (op == OP_RD && m_streak < MAXS) m_streak++;
    end
  endtask

  task automatic cycle();
    model_step();
    @(negedge clk133);
    check("cmd_valid", cmdValid, (m_phase == P_ISS));
    check("overflow", refreshOverflow, m_ovf);
  endtask

  task automatic drive_random(input int p_rd, input int p_wr);
    if (m_rd_win) rdReq = 1'b0;
    else if (!rdReq && $urandom_range(0, 99) < p_rd) begin
      rdReq = 1'b1;
      rdAddr = 24'($urandom());
    end
    if (m_wr_win) wrReq = 1'b0;
    else if (!wrReq && $urandom_range(0, 99) < p_wr) begin
      wrReq = 1'b1;
      wrAddr = 24'($urandom());
      wrData = $urandom();
    end
    cmdReady = ($urandom_range(0, 99) < 60);
    if (m_phase == P_WAIT) begin
      if (m_done_wait == 0) cmdDone = 1'b1;
      else begin
        cmdDone = 1'b0;
        m_done_wait--;
      end
    end else begin
      cmdDone = ($urandom_range(0, 19) == 0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; initDone = 1'b1; rdReq = 1'b0; wrReq = 1'b0; cmdReady = 1'b1; cmdDone = 1'b0;
    repeat (2) cycle();
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, cmdValid, 1'b0);
    check({tag, "_op"}, cmdOp, 2'b00);
    check({tag, "_addr"}, cmdAddr, 24'h0);
    check({tag, "_data"}, cmdData, 32'h0);
    check({tag, "_gnts"}, {rdGnt, wrGnt}, 2'b00);
  endtask

  // Monitor: pops an expectation whenever a new command appears on the channel.
  logic        mon_prev_valid = 1'b0;
  logic [1:0]  mon_prev_op = 2'b00;
  logic [23:0] mon_prev_addr = '0;
  logic [31:0] mon_prev_data = '0;
  logic [57:0] mon_e;
  always @(negedge clk133) begin
    check("gnt_exclusive", rdGnt & wrGnt, 1'b0);
    if (cmdValid && !mon_prev_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_cmd: got op %0b addr 0x%0h, expected no command at %0t",
                 cmdOp, cmdAddr, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("cmd_op", cmdOp, mon_e[57:56]);
        check("cmd_addr", cmdAddr, mon_e[55:32]);
        check("cmd_data", cmdData, mon_e[31:0]);
        check("rd_gnt", rdGnt, (mon_e[57:56] == OP_RD));
        check("wr_gnt", wrGnt, (mon_e[57:56] == OP_WR));
      end
    end else begin
      check("gnt_late", {rdGnt, wrGnt}, 2'b00);
      if (cmdValid) begin
        check("hold_op", cmdOp, mon_prev_op);
        check("hold_addr", cmdAddr, mon_prev_addr);
        check("hold_data", cmdData, mon_prev_data);
      end else begin
        check("op_idle", cmdOp, 2'b00);
      end
    end
    mon_prev_valid = cmdValid;
    mon_prev_op    = cmdOp;
    mon_prev_addr  = cmdAddr;
    mon_prev_data  = cmdData;
  end

  initial begin
    bit gnt_seen, valid_seen, found;
    int k, reads_since, writes;

    // reset, then init never completes while a read waits
    rst = 1'b1; initDone = 1'b0; cmdReady = 1'b1;
    repeat (3) cycle();
    check_all_zero("reset");
    check("reset_ovf", refreshOverflow, 1'b0);
    rst = 1'b0; rdReq = 1'b1; rdAddr = 24'h0abcde;
    gnt_seen = 0; valid_seen = 0;
    for (int i = 0; i < 2000; i++) begin
      cycle();
      if (rdGnt) gnt_seen = 1;
      if (cmdValid) valid_seen = 1;
    end
    check("noinit_gnt", gnt_seen, 1'b0);
    check("noinit_valid", valid_seen, 1'b0);

    // single read latency and spacing to the next grant
    do_reset();
    rdReq = 1'b1; rdAddr = 24'h012345; cmdReady = 1'b1; cmdDone = 1'b0;
    cycle();
    check("rd_n1_gnt", rdGnt, 1'b1);
    check("rd_n1_op", cmdOp, OP_RD);
    check("rd_n1_addr", cmdAddr, 24'h012345);
    rdAddr = 24'h054321;
    found = 0;
    for (k = 1; k <= 20; k++) begin
      cmdDone = (k == 3);
      cycle();
      if (k == 1) check("rd_accepted", {cmdValid, rdGnt}, 2'b00);
      if (rdGnt) begin
        found = 1;
        break;
      end
    end
    check("rd_second_found", found, 1'b1);
    check("rd_gap_min3", (k >= 3), 1'b1);
    rdReq = 1'b0; cmdDone = 1'b0;

    // reads and writes both pending: every ninth grant is the write
    do_reset();
    rdReq = 1'b1; wrReq = 1'b1; rdAddr = 24'h100000; wrAddr = 24'h200000; wrData = 32'h1;
    cmdReady = 1'b1; cmdDone = 1'b1;
    reads_since = 0; writes = 0;
    for (int i = 0; i < 600 && writes < 3; i++) begin
      cycle();
      if (rdGnt) begin
        reads_since++;
        rdAddr = rdAddr + 24'd1;
      end
      if (wrGnt) begin
        check("streak_len", reads_since, MAXS);
        reads_since = 0;
        writes++;
        wrAddr = wrAddr + 24'd1;
        wrData = wrData + 32'd1;
      end
    end
    check("streak_writes", writes, 3);
    rdReq = 1'b0; wrReq = 1'b0;

    // urgent refresh beats a waiting read; the read follows
    do_reset();
    wrReq = 1'b1; wrAddr = 24'h00beef; wrData = 32'h5a5a5a5a; cmdReady = 1'b1; cmdDone = 1'b0;
    cycle();
    check("ref_setup_wr", wrGnt, 1'b1);
    wrReq = 1'b0;
    for (int i = 0; i < 1000 && m_pend < 4; i++) cycle();
    check("ref_pend4_reached", m_pend, 4);
    rdReq = 1'b1; rdAddr = 24'h0a0b0c; cmdDone = 1'b1;
    cycle();
    cmdDone = 1'b0;
    cycle();
    check("ref_wins_op", cmdOp, OP_REF);
    check("ref_wins_addr", cmdAddr, 24'h0);
    check("ref_wins_gnts", {rdGnt, wrGnt}, 2'b00);
    cmdDone = 1'b1;
    found = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (rdGnt) begin
        found = 1;
        break;
      end
    end
    check("rd_after_ref", found, 1'b1);
    rdReq = 1'b0;

    // sequencer never completes: backlog saturates and overflow sticks
    cmdDone = 1'b0;
    for (int i = 0; i < 9 * RI + 10; i++) cycle();
    check("ovf_set", refreshOverflow, 1'b1);
    cmdDone = 1'b1;
    repeat (100) cycle();
    check("ovf_sticky", refreshOverflow, 1'b1);
    initDone = 1'b0;
    repeat (5) cycle();
    check_all_zero("init_low");
    check("ovf_kept_init_low", refreshOverflow, 1'b1);
    initDone = 1'b1;

    // stalled write holds its payload; rst aborts it
    wrReq = 1'b1; wrAddr = 24'h345678; wrData = 32'hdeadbeef; cmdReady = 1'b1;
    found = 0;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (wrGnt) begin
        found = 1;
        break;
      end
    end
    check("stall_wr_granted", found, 1'b1);
    wrReq = 1'b0; cmdReady = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("stall_valid", cmdValid, 1'b1);
      check("stall_op", cmdOp, OP_WR);
      check("stall_addr", cmdAddr, 24'h345678);
      check("stall_data", cmdData, 32'hdeadbeef);
    end
    rst = 1'b1;
    cycle();
    check_all_zero("rst_abort");
    check("rst_abort_ovf", refreshOverflow, 1'b0);
    rst = 1'b0; cmdReady = 1'b1;
    repeat (20) cycle();

    // randomized traffic with occasional init drops and resets
    for (int phase = 0; phase < 3; phase++) begin
      for (int i = 0; i < 4000; i++) begin
        case (phase)
          0:       drive_random(30, 20);
          1:       drive_random(4, 4);
          default: drive_random(90, 90);
        endcase
        if ($urandom_range(0, 399) == 0) initDone = 1'b0;
        else if (!initDone && $urandom_range(0, 3) == 0) initDone = 1'b1;
        rst = ($urandom_range(0, 999) == 0);
        cycle();
      end
    end
    rst = 1'b0; initDone = 1'b1;
    repeat (200) begin
      drive_random(0, 0);
      cycle();
    end
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
